// File: rtl/cache_arbiter.sv
// Purpose: arbitrates I-cache and D-cache line requests onto one physical-memory port; ties alternate.
// Latency: strobe the cycle after grant; x_resp one cycle after pmem_resp; one IDLE bubble before the next grant.
// Backpressure: requests are held until x_resp; memory stalls by withholding pmem_resp.
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t            state;
  logic              last_grant_d;  // 0: I-cache won last, 1: D-cache won last
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic [LINE_W-1:0] line_buf;

  logic d_req;
  logic grant_d;

  // Arbitration: D wins when it is the only requester, or on a tie when I was granted last.
  always_comb begin
    d_req   = d_read | d_write;
    grant_d = d_req & (~i_read | ~last_grant_d);
  end

  // The memory side sees only latched copies, so requester changes mid-transaction are harmless.
  assign pmem_address = lat_addr;
  assign pmem_wdata   = lat_wdata;
  assign i_rdata      = line_buf;
  assign d_rdata      = line_buf;

  // Control FSM: grant, hold strobe until pmem_resp, pulse the served side's resp, then idle one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      lat_write    <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      line_buf     <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          if (i_read || d_req) begin
            last_grant_d <= grant_d;
            if (grant_d) begin
              // A simultaneous read+write from the D-cache is taken as the writeback.
              state      <= SERVE_D;
              lat_addr   <= d_address;
              lat_write  <= d_write;
              lat_wdata  <= d_write ? d_wdata : '0;
              pmem_read  <= ~d_write;
              pmem_write <= d_write;
            end else begin
              state      <= SERVE_I;
              lat_addr   <= i_address;
              lat_write  <= 1'b0;
              lat_wdata  <= '0;
              pmem_read  <= 1'b1;
              pmem_write <= 1'b0;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            state      <= DONE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            if (!lat_write) begin
              line_buf <= pmem_rdata;
            end
            i_resp <= (state == SERVE_I);
            d_resp <= (state == SERVE_D);
          end
        end
        DONE: begin
          // Stray pmem_resp here is ignored; the next grant waits for the IDLE bubble.
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Purpose: self-checking bench for cache_arbiter against a transaction-level arbitration model.
// Latency: drives and samples 1 time unit after each rising edge.
// Backpressure: memory latency chosen per transaction; every wait is bounded.
module tb_cache_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int vectors = 0;
  int miscompares = 0;

  // Model: which side won the most recent grant (0 = I, 1 = D).
  bit model_last_d = 1'b0;

  cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Fair arbitration rule: a lone requester wins; a tie goes to whoever did not win last.
  function automatic bit pick_d(input bit ir, input bit dr);
    if (ir && dr) return !model_last_d;
    return dr;
  endfunction

  // One memory transaction: waits for the grant, answers after lat strobe cycles, checks the response.
  task automatic serve_txn(input bit exp_d, input bit exp_wr, input logic [ADDR_W-1:0] exp_addr,
                           input logic [LINE_W-1:0] exp_wdata, input int lat, input bit scramble);
    int waitc;
    logic [LINE_W-1:0] rdat;
    waitc = 0;
    while (!(pmem_read || pmem_write) && waitc < 10) begin
      tick();
      waitc++;
    end
    vectors++;
    if (waitc >= 10) begin
      miscompares++;
      $display("FAIL grant_timeout: no strobe within %0d cycles, required one", waitc);
      return;
    end
    rdat = rand_line();
    for (int n = 1; n <= lat; n++) begin
      vectors++;
      if ({pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp} !==
          {~exp_wr, exp_wr, exp_addr, exp_wdata, 2'b00}) begin
        miscompares++;
        $display("FAIL strobe_cycle%0d: rd=%b wr=%b addr=%h wdata=%h resp=%b%b, required rd=%b wr=%b addr=%h wdata=%h resp=00",
                 n, pmem_read, pmem_write, pmem_address, pmem_wdata, i_resp, d_resp,
                 ~exp_wr, exp_wr, exp_addr, exp_wdata);
      end
      if (scramble && n == 1) begin
        if (exp_d) begin
          d_address = ADDR_W'($urandom);
          d_wdata   = rand_line();
        end else begin
          i_address = ADDR_W'($urandom);
        end
      end
      if (n == lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = rdat;
      end
      tick();
    end
    vectors++;
    if ({i_resp, d_resp, pmem_read, pmem_write} !== {~exp_d, exp_d, 2'b00}) begin
      miscompares++;
      $display("FAIL done_pulse: i_resp=%b d_resp=%b rd=%b wr=%b, required i_resp=%b d_resp=%b rd=0 wr=0",
               i_resp, d_resp, pmem_read, pmem_write, ~exp_d, exp_d);
    end
    if (!exp_wr) begin
      vectors++;
      if ((exp_d ? d_rdata : i_rdata) !== rdat) begin
        miscompares++;
        $display("FAIL fill_data: got %h, required %h", exp_d ? d_rdata : i_rdata, rdat);
      end
    end
    pmem_resp  = 1'b0;
    pmem_rdata = rand_line();
    if (exp_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    tick();
    vectors++;
    if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000) begin
      miscompares++;
      $display("FAIL idle_bubble: resp=%b%b rd=%b wr=%b, required all 0", i_resp, d_resp, pmem_read, pmem_write);
    end
    if (!exp_wr) begin
      vectors++;
      if (d_rdata !== rdat || i_rdata !== rdat) begin
        miscompares++;
        $display("FAIL buffer_hold: i_rdata=%h d_rdata=%h, required %h", i_rdata, d_rdata, rdat);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_last_d = 1'b0;
  endtask

  task automatic test_reset();
    i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    do_reset();
    vectors++;
    if ({i_resp, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, i_rdata, d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: resp=%b%b rd=%b wr=%b addr=%h wdata=%h irdata=%h drdata=%h, required all 0",
               i_resp, d_resp, pmem_read, pmem_write, pmem_address, pmem_wdata, i_rdata, d_rdata);
    end
  endtask

  task automatic test_d_read();
    d_read = 1; d_address = 16'h1230;
    serve_txn(1'b1, 1'b0, 16'h1230, '0, 3, 1'b0);
    model_last_d = 1'b1;
  endtask

  task automatic test_tie_alternation();
    bit w;
    do_reset();
    i_read = 1; i_address = 16'h0A00;
    d_read = 1; d_address = 16'h0B00;
    for (int k = 0; k < 4; k++) begin
      w = pick_d(i_read, d_read);
      vectors++;
      if (w !== ((k % 2) == 0)) begin
        miscompares++;
        $display("FAIL tie_model%0d: model picked d=%b, required d=%b", k, w, (k % 2) == 0);
      end
      serve_txn(w, 1'b0, w ? d_address : i_address, '0, 1 + (k % 3), 1'b0);
      model_last_d = w;
      if (w) d_read = 1; else i_read = 1;
    end
    i_read = 0; d_read = 0;
    tick(); tick(); tick(); tick();
    vectors++;
    if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000) begin
      miscompares++;
      $display("FAIL tie_drain: resp=%b%b rd=%b wr=%b, required all 0", i_resp, d_resp, pmem_read, pmem_write);
    end
  endtask

  task automatic test_d_write_stable();
    logic [LINE_W-1:0] wd;
    wd = 128'h0123456789ABCDEF0123456789ABCDEF;
    d_write = 1; d_address = 16'h4000; d_wdata = wd;
    serve_txn(1'b1, 1'b1, 16'h4000, wd, 4, 1'b1);
    model_last_d = 1'b1;
  endtask

  task automatic test_stray_resp();
    pmem_resp = 1; pmem_rdata = rand_line();
    tick();
    pmem_resp = 0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000) begin
        miscompares++;
        $display("FAIL stray_resp%0d: resp=%b%b rd=%b wr=%b, required all 0", k, i_resp, d_resp, pmem_read, pmem_write);
      end
      tick();
    end
    i_read = 1; i_address = 16'h5550;
    serve_txn(1'b0, 1'b0, 16'h5550, '0, 2, 1'b0);
    model_last_d = 1'b0;
  endtask

  task automatic test_reset_mid_serve();
    int waitc;
    i_read = 1; i_address = 16'h2220;
    waitc = 0;
    while (!pmem_read && waitc < 10) begin
      tick();
      waitc++;
    end
    tick();
    rst = 1;
    tick();
    vectors++;
    if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_mid_serve: resp=%b%b rd=%b wr=%b, required all 0", i_resp, d_resp, pmem_read, pmem_write);
    end
    rst = 0; i_read = 0; model_last_d = 1'b0;
    pmem_resp = 1; pmem_rdata = rand_line();
    tick();
    pmem_resp = 0;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000) begin
        miscompares++;
        $display("FAIL late_resp%0d: resp=%b%b rd=%b wr=%b, required all 0", k, i_resp, d_resp, pmem_read, pmem_write);
      end
      tick();
    end
    i_read = 1; i_address = 16'h3330;
    serve_txn(1'b0, 1'b0, 16'h3330, '0, 1, 1'b0);
    model_last_d = 1'b0;
  endtask

  task automatic test_rw_both();
    logic [LINE_W-1:0] wd;
    wd = rand_line();
    d_read = 1; d_write = 1; d_address = 16'h7770; d_wdata = wd;
    serve_txn(1'b1, 1'b1, 16'h7770, wd, 2, 1'b0);
    model_last_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({d_resp, pmem_read, pmem_write} !== 3'b000) begin
        miscompares++;
        $display("FAIL rw_single%0d: d_resp=%b rd=%b wr=%b, required all 0", k, d_resp, pmem_read, pmem_write);
      end
    end
  endtask

  task automatic test_random();
    bit w;
    bit wr;
    int guard;
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(1, 7);
      i_read    = sel[0];
      d_read    = sel[1];
      d_write   = sel[2];
      i_address = ADDR_W'($urandom);
      d_address = ADDR_W'($urandom);
      d_wdata   = rand_line();
      guard = 0;
      while ((i_read || d_read || d_write) && guard < 3) begin
        w  = pick_d(i_read, d_read || d_write);
        wr = w && d_write;
        serve_txn(w, wr, w ? d_address : i_address, wr ? d_wdata : '0,
                  $urandom_range(1, 4), 1'($urandom_range(0, 1)));
        model_last_d = w;
        guard++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_tie_alternation();
    test_d_write_stable();
    test_stray_resp();
    test_reset_mid_serve();
    test_rw_both();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
